// File: rtl/fifo_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_master_ctrl
// Brief    : Register-mapped FIFO master with built-in storage, sticky W1C
//            error flags, level/threshold status, flush control, a registered
//            read path with response pulse and a maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        addr,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              resp,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] C_ADDR_DATA  = 2'd0;
    localparam logic [1:0] C_ADDR_STAT  = 2'd1;
    localparam logic [1:0] C_ADDR_CTRL  = 2'd2;
    localparam logic [1:0] C_ADDR_LEVEL = 2'd3;

    // FIFO storage (contents are intentionally not reset)
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_udf;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_rdata;
    logic              r_resp;
    logic              r_irq;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_full;
    logic              w_empty;
    logic              w_thresh;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_stat;
    logic [DATA_W-1:0] w_rd_val;

    // Simultaneous write and read strobes are treated as no access at all
    assign w_wr_acc = enable & write & ~read;
    assign w_rd_acc = enable & read & ~write;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_thresh = (r_count >= CNT_W'(THRESH));

    assign w_push   = w_wr_acc && (addr == C_ADDR_DATA) && !w_full;
    assign w_pop    = w_rd_acc && (addr == C_ADDR_DATA) && !w_empty;

    assign w_stat   = DATA_W'({w_thresh, r_udf, r_ovf, w_empty, w_full});

    // Read-data mux; an empty DATA read returns zero
    always_comb begin
        w_rd_val = '0;
        case (addr)
            C_ADDR_DATA:  w_rd_val = w_empty ? '0 : r_mem[r_rd_ptr];
            C_ADDR_STAT:  w_rd_val = w_stat;
            C_ADDR_CTRL:  w_rd_val = DATA_W'(r_irq_en);
            C_ADDR_LEVEL: w_rd_val = DATA_W'(r_count);
            default:      w_rd_val = '0;
        endcase
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers, level, flags, control and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
            r_resp   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_resp <= w_wr_acc | w_rd_acc;
            r_irq  <= r_irq_en & (r_ovf | r_udf | w_thresh);

            if (w_rd_acc) begin
                r_rdata <= w_rd_val;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_count  <= r_count + CNT_W'(1);
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count  <= r_count - CNT_W'(1);
            end

            if (w_wr_acc) begin
                case (addr)
                    C_ADDR_DATA: begin
                        if (w_full) r_ovf <= 1'b1;
                    end
                    C_ADDR_STAT: begin
                        if (wdata[2]) r_ovf <= 1'b0;
                        if (wdata[3]) r_udf <= 1'b0;
                    end
                    C_ADDR_CTRL: begin
                        // A flush write leaves irq_en as it was
                        if (wdata[1]) begin
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                            r_count  <= '0;
                        end else begin
                            r_irq_en <= wdata[0];
                        end
                    end
                    default: ;
                endcase
            end

            if (w_rd_acc && (addr == C_ADDR_DATA) && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign rdata = r_rdata;
    assign resp  = r_resp;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_fifo_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_master_ctrl
// Brief    : Self-checking bench for fifo_master_ctrl with a queue-based
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_master_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int THRESH = 12;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [1:0]        addr;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              resp;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic              m_ovf;
    logic              m_udf;
    logic              m_irq_en;
    logic [DATA_W-1:0] m_rdata;
    logic              m_resp;
    logic              m_irq;

    fifo_master_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .addr   (addr),
        .write  (write),
        .read   (read),
        .wdata  (wdata),
        .rdata  (rdata),
        .resp   (resp),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_stat();
        int n;
        n = m_q.size();
        return DATA_W'({(n >= THRESH), m_udf, m_ovf, (n == 0), (n == DEPTH)});
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_irq_en = 1'b0;
        m_rdata  = '0;
        m_resp   = 1'b0;
        m_irq    = 1'b0;
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, compare
    task automatic cycle(input logic en, input logic [1:0] a, input logic wr,
                         input logic rd, input logic [DATA_W-1:0] wd);
        logic acc;
        logic nxt_irq;
        enable = en;
        addr   = a;
        write  = wr;
        read   = rd;
        wdata  = wd;
        @(posedge clk);
        #1;
        acc     = en && (wr != rd);
        nxt_irq = m_irq_en && (m_ovf || m_udf || (m_q.size() >= THRESH));
        if (acc && rd) begin
            case (a)
                2'd0: begin
                    if (m_q.size() > 0) m_rdata = m_q.pop_front();
                    else begin
                        m_rdata = '0;
                        m_udf   = 1'b1;
                    end
                end
                2'd1: m_rdata = model_stat();
                2'd2: m_rdata = DATA_W'(m_irq_en);
                default: m_rdata = DATA_W'(m_q.size());
            endcase
        end
        if (acc && wr) begin
            case (a)
                2'd0: begin
                    if (m_q.size() < DEPTH) m_q.push_back(wd);
                    else m_ovf = 1'b1;
                end
                2'd1: begin
                    if (wd[2]) m_ovf = 1'b0;
                    if (wd[3]) m_udf = 1'b0;
                end
                2'd2: begin
                    if (wd[1]) m_q.delete();
                    else m_irq_en = wd[0];
                end
                default: ;
            endcase
        end
        m_resp = acc;
        m_irq  = nxt_irq;
        check("resp",  resp,  m_resp);
        check("irq",   irq,   m_irq);
        check("rdata", rdata, m_rdata);
        enable = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        cycle(1'b1, 2'd0, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cycle(1'b1, a, 1'b0, 1'b1, '0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [DATA_W-1:0] d);
        cycle(1'b1, a, 1'b1, 1'b0, d);
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 1'b0, 1'b0, '0);
    endtask

    logic [DATA_W-1:0] saved[$];

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        addr   = '0;
        write  = 1'b0;
        read   = 1'b0;
        wdata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 0);
        check("rst_resp",  resp,  0);
        check("rst_irq",   irq,   0);
        rst_n = 1'b1;

        // Reset state readback
        rd_reg(2'd1);
        check("stat_after_reset", rdata, 8'h02);
        rd_reg(2'd3);
        check("level_after_reset", rdata, 8'h00);

        // Basic ordering
        push(8'h11); push(8'h22); push(8'h33);
        rd_reg(2'd0); check("pop0", rdata, 8'h11);
        rd_reg(2'd0); check("pop1", rdata, 8'h22);
        rd_reg(2'd0); check("pop2", rdata, 8'h33);
        rd_reg(2'd1); check("stat_empty", rdata, 8'h02);

        // Fill, overflow, drain, clear ovf
        saved.delete();
        for (int i = 0; i < DEPTH; i++) begin
            saved.push_back(8'(8'h40 + i));
            push(8'(8'h40 + i));
        end
        rd_reg(2'd1); check("stat_full", rdata, 8'h11);
        push(8'hAA);
        rd_reg(2'd1); check("stat_ovf", rdata, 8'h15);
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(2'd0);
            check("drain", rdata, saved[i]);
        end
        wr_reg(2'd1, 8'h04);
        rd_reg(2'd1); check("stat_ovf_clr", rdata, 8'h02);

        // Underflow and interrupt
        rd_reg(2'd0); check("udf_rdata", rdata, 8'h00);
        rd_reg(2'd1); check("stat_udf", rdata, 8'h0A);
        wr_reg(2'd2, 8'h01);
        idle(); check("irq_set", irq, 1);
        wr_reg(2'd1, 8'h08);
        idle(); check("irq_clr", irq, 0);

        // Wrap-around and flush
        for (int i = 0; i < 10; i++) push(8'(i));
        for (int i = 0; i < 10; i++) rd_reg(2'd0);
        saved.delete();
        for (int i = 0; i < 12; i++) begin
            saved.push_back(8'(8'hC0 + i));
            push(8'(8'hC0 + i));
        end
        rd_reg(2'd3); check("level12", rdata, 8'd12);
        rd_reg(2'd1); check("stat_thresh", rdata, 8'h10);
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'd0);
            check("wrap_order", rdata, saved[i]);
        end
        wr_reg(2'd2, 8'h02);
        rd_reg(2'd3); check("level_flush", rdata, 8'd0);
        rd_reg(2'd1); check("stat_flush", rdata, 8'h02);
        rd_reg(2'd2); check("irq_en_kept", rdata, 8'h01);

        // Both strobes: ignored
        push(8'h77);
        cycle(1'b1, 2'd0, 1'b1, 1'b1, 8'h99);
        check("both_no_resp", resp, 0);
        rd_reg(2'd3); check("both_level", rdata, 8'd1);

        // Randomized traffic, biased toward DATA
        for (int i = 0; i < 400; i++) begin
            logic [1:0] a;
            logic       en, wr, rd;
            logic [DATA_W-1:0] d;
            en = ($urandom_range(0, 9) != 0);
            a  = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 15) == 0) ? wr : ~wr;
            d  = 8'($urandom());
            if (a == 2'd2 && d[1] && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            cycle(en, a, wr, rd, d);
        end

        // Reset in the middle of a burst
        push(8'h5A); push(8'h6B);
        wr_reg(2'd1, 8'h0C);
        while (m_q.size() > 1) rd_reg(2'd0);
        rd_reg(2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", rdata, 0);
        check("midrst_resp",  resp,  0);
        check("midrst_irq",   irq,   0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_reg(2'd3); check("midrst_level", rdata, 8'd0);
        rd_reg(2'd2); check("midrst_ctrl", rdata, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_master_ctrl.md
Name: fifo_master_ctrl

Overview:
- Parametrised next-generation register-mapped FIFO master.
- Bus side uses the same enable/addr/write/read strobe interface as the existing master.
- Internal FIFO storage of configurable width and depth, built in (no external fifo_mem instance).
- Adds sticky write-1-to-clear error flags, a level register, a fill threshold, a flush control, a registered read path with a response pulse, and a maskable interrupt.

Parameters:
DATA_W, 8, FIFO word and register width; must be >= 8 and >= $clog2(DEPTH)+1
DEPTH, 16, FIFO entries; power of two, >= 2
THRESH, 12, level at or above which the thresh flag is set; 1..DEPTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  access strobe, qualifies addr/write/read for one cycle
addr  input  2  register select: 0 DATA, 1 STAT, 2 CTRL, 3 LEVEL
write  input  1  write access when enable=1
read  input  1  read access when enable=1
wdata  input  DATA_W  write data
rdata  output  DATA_W  registered read data, valid while resp=1
resp  output  1  one-cycle pulse, one cycle after each accepted access
irq  output  1  registered interrupt

Behaviour:
- Reset (rst_n=0, asynchronous): rdata=0, resp=0, irq=0, wr_ptr=rd_ptr=0, count=0, sticky flags=0, CTRL=0. FIFO memory contents are not reset.
- Accepted access: enable=1 with exactly one of write/read high.
  - enable=1 with write=read=1 is ignored: no state change, no resp.
  - enable=0 is idle.
- resp is asserted in cycle N+1 for an access accepted in cycle N.
  - For reads, rdata is updated in cycle N+1 and holds until the next read.
  - For writes, rdata is unchanged.
- DATA (addr 0):
  - Write when count<DEPTH: mem[wr_ptr]<=wdata, wr_ptr+1 (wraps modulo DEPTH), count+1.
  - Write when count==DEPTH: data dropped, pointers unchanged, ovf sticky set.
  - Read when count>0: rdata<=mem[rd_ptr], rd_ptr+1 (wraps), count-1.
  - Read when count==0: rdata<=0, pointers unchanged, udf sticky set.
- STAT (addr 1), read-only except W1C:
  - Bit fields: bit0 full (count==DEPTH), bit1 empty (count==0), bit2 ovf sticky, bit3 udf sticky, bit4 thresh (count>=THRESH), bits above 4 read 0.
  - Write: wdata[2]=1 clears ovf; wdata[3]=1 clears udf; other bits ignored.
  - A set event and a clear in the same cycle cannot coincide (single port), so no priority rule is needed.
- CTRL (addr 2):
  - bit0 irq_en (read/write).
  - bit1 flush: write 1 resets wr_ptr, rd_ptr and count next edge; sticky flags and irq_en untouched; reads back 0.
  - Other bits read 0.
- LEVEL (addr 3): read returns count zero-extended to DATA_W. Writes are accepted (resp pulses) with no effect.
- Status bits full/empty/thresh reflect count after the previous edge (combinational from registered count, sampled into rdata on read).
- irq <= irq_en & (ovf | udf | thresh), registered, so it follows the cause by one cycle.
- Counter width is $clog2(DEPTH)+1 so count==DEPTH is representable. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-sequence: all pointers, flags and outputs return to reset values asynchronously. A pending resp is cancelled.

Test Plan:
- Reset, then read STAT -> resp one cycle later, rdata=0x02 (empty only); LEVEL reads 0; irq=0.
- Push 0x11,0x22,0x33, then pop 3 -> rdata 0x11,0x22,0x33 in order, each with one resp pulse; STAT then 0x02.
- Push 16 words (DEPTH=16) -> STAT=0x11 (full+thresh); 17th push 0xAA dropped, STAT=0x15; pop 16 returns the original data; write STAT 0x04 -> STAT=0x02.
- Pop when empty -> rdata=0, STAT=0x0A; write CTRL=0x01 -> irq=1 one cycle later; write STAT 0x08 -> irq=0 one cycle later.
- Wrap-around: push 10, pop 10, push 12 -> LEVEL=12, thresh=1, data order preserved across pointer wrap; CTRL=0x02 flush -> LEVEL=0, STAT=0x02, irq_en still 1.
- enable=1 with write=read=1 on DATA -> no resp, LEVEL unchanged. Assert rst_n low mid-burst -> outputs 0 immediately, LEVEL=0 after release.
